// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin arbiter feeding one value at a time to the 7-segment display driver
module seg_display_arbiter #(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 o_cs,
    output logic [31:0]          o_data,
    output logic [1:0]           o_owner,
    output logic                 busy
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       owner_q, owner_d;

    // Padded to four requesters so the search indexes with an exact 2-bit select.
    logic [3:0]   req_pad;
    logic [127:0] data_pad;
    logic [2:0]   search_sum;
    logic [1:0]   grant_idx;
    logic         grant_found;
    logic [3:0]   grant_onehot;

    assign req_pad  = 4'(req);
    assign data_pad = 128'(req_data);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        search_sum  = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            search_sum = {1'b0, ptr_q} + 3'(k);
            if (search_sum >= 3'(NREQ)) begin
                search_sum = search_sum - 3'(NREQ);
            end
            if (!grant_found && req_pad[search_sum[1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = search_sum[1:0];
            end
        end
    end

    assign grant_onehot = 4'b0001 << grant_idx;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        data_d  = data_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    data_d  = data_pad[{grant_idx, 5'b0} +: 32];
                    ack_d   = grant_onehot[NREQ-1:0];
                    owner_d = grant_idx;
                    ptr_d   = (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = HOLD_LOAD;
                state_d = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= 32'd0;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            owner_q <= owner_d;
        end
    end

    assign ack     = ack_q;
    assign o_cs    = (state_q == S_WRITE);
    assign busy    = (state_q != S_IDLE);
    assign o_data  = data_q;
    assign o_owner = owner_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - self-checking bench for seg_display_arbiter
module tb_seg_display_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [95:0] req_data;
    logic [2:0]  ack;
    logic        o_cs;
    logic [31:0] o_data;
    logic [1:0]  o_owner;
    logic        busy;

    logic        rst_z;
    logic [2:0]  req_z;
    logic [95:0] req_data_z;
    logic [2:0]  ack_z;
    logic        cs_z;
    logic [31:0] data_z;
    logic [1:0]  owner_z;
    logic        busy_z;

    seg_display_arbiter #(.NREQ(3), .HOLD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .o_cs(o_cs), .o_data(o_data), .o_owner(o_owner), .busy(busy)
    );

    seg_display_arbiter #(.NREQ(3), .HOLD_CYCLES(0)) dut_z (
        .clk(clk), .reset(rst_z), .req(req_z), .req_data(req_data_z),
        .ack(ack_z), .o_cs(cs_z), .o_data(data_z), .o_owner(owner_z), .busy(busy_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ack;
        logic [1:0]  owner;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [2:0] req;
        int         g;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] data_v[3];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        prev_cs  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_data();
        for (int i = 0; i < 3; i++) data_v[i] = $urandom | 32'h1;
        req_data = {data_v[2], data_v[1], data_v[0]};
    endtask

    task automatic push_exp(input int g);
        exp_t e;
        e.ack   = 3'b001 << g;
        e.owner = 2'(g);
        e.data  = data_v[g];
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Scoreboard: every display write must match the next expected grant.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_cs) begin
                if (sb.size() == 0) begin
                    check("unexpected_cs", 32'(o_owner), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_ack", 32'(ack), 32'(e.ack));
                    check("sb_owner", 32'(o_owner), 32'(e.owner));
                    check("sb_data", o_data, e.data);
                end
            end
            if (o_cs && prev_cs) check("cs_back_to_back", 32'd1, 32'd0);
            if ((|ack) != o_cs) check("ack_vs_cs", 32'(ack), {31'd0, o_cs});
        end
        prev_cs <= o_cs && !reset;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   t;
        int   last_c;
        int   c0;
        int   n_busy;
        int   n_cs;

        vecs[0] = '{3'b001, 0};
        vecs[1] = '{3'b001, 0};
        vecs[2] = '{3'b110, 1};
        vecs[3] = '{3'b011, 0};
        vecs[4] = '{3'b101, 2};
        vecs[5] = '{3'b110, 1};
        vecs[6] = '{3'b111, 2};
        vecs[7] = '{3'b100, 2};
        vecs[8] = '{3'b010, 1};

        reset      = 1'b1;
        req        = 3'b000;
        req_data   = '0;
        rst_z      = 1'b1;
        req_z      = 3'b011;
        req_data_z = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cs", 32'(o_cs), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_owner", 32'(o_owner), 32'd0);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_cs", 32'(o_cs), 32'd0);
            check("idle_ack", 32'(ack), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_data", o_data, 32'd0);
        end

        // Single request
        data_v[1] = 32'h1234_5678;
        req_data  = {32'h0, data_v[1], 32'h0};
        req       = 3'b010;
        push_exp(1);
        @(negedge clk);
        check("single_ack", 32'(ack), 32'b010);
        check("single_cs", 32'(o_cs), 32'd1);
        req    = 3'b000;
        n_busy = 0;
        n_cs   = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) n_busy++;
            if (o_cs) n_cs++;
            @(negedge clk);
        end
        check("single_busy_len", 32'(n_busy), 32'd5);
        check("single_cs_count", 32'(n_cs), 32'd1);
        check("single_data_held", o_data, 32'h1234_5678);
        check("single_owner_held", 32'(o_owner), 32'd1);

        // Table of request patterns from a fresh pointer
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int v = 0; v < 9; v++) begin
            wait_idle();
            load_data();
            req = vecs[v].req;
            push_exp(vecs[v].g);
            @(negedge clk);
            check($sformatf("vec%0d_ack", v), 32'(ack), 32'(3'b001 << vecs[v].g));
            check($sformatf("vec%0d_cs", v), 32'(o_cs), 32'd1);
            req = 3'b000;
        end
        wait_idle();
        check("vec_sb_empty", 32'(sb.size()), 32'd0);

        // Round-robin with all requests held from reset
        reset = 1'b1;
        req   = 3'b111;
        load_data();
        push_exp(0); push_exp(1); push_exp(2); push_exp(0); push_exp(1);
        @(negedge clk);
        reset  = 1'b0;
        last_c = 0;
        for (int n = 0; n < 5; n++) begin
            t = 0;
            while (!o_cs && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!o_cs) begin
                check($sformatf("rr_timeout%0d", n), 32'd0, 32'd1);
            end else begin
                if (n > 0) check($sformatf("rr_spacing%0d", n), 32'(cyc - last_c), 32'd6);
                last_c = cyc;
                if (n == 4) req = 3'b000;
                @(negedge clk);
            end
        end
        req = 3'b000;
        wait_idle();
        check("rr_sb_empty", 32'(sb.size()), 32'd0);

        // Requests raised during HOLD wait for IDLE and respect the pointer
        load_data();
        req = 3'b001;
        push_exp(0);
        @(negedge clk);
        check("hold_first_ack", 32'(ack), 32'b001);
        c0  = cyc;
        req = 3'b000;
        @(negedge clk);
        check("hold_busy", 32'(busy), 32'd1);
        req = 3'b101;
        push_exp(2);
        t = 0;
        while (ack == 3'b000 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("hold_second_ack", 32'(ack), 32'b100);
        check("hold_spacing", 32'(cyc - c0), 32'd6);
        req = 3'b000;
        wait_idle();

        // Reset in the middle of HOLD
        load_data();
        req = 3'b001;
        push_exp(0);
        @(negedge clk);
        check("mid_ack", 32'(ack), 32'b001);
        req = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_cs", 32'(o_cs), 32'd0);
        check("mid_data", o_data, 32'd0);
        check("mid_owner", 32'(o_owner), 32'd0);
        check("mid_ack_clr", 32'(ack), 32'd0);
        req = 3'b111;
        push_exp(0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_regrant_ack", 32'(ack), 32'b001);
        req = 3'b000;
        wait_idle();
        check("mid_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-hold build: grants every second cycle, owners alternate
        rst_z = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("zero_cs%0d", k), 32'(cs_z), 32'((k % 2) == 0));
            if ((k % 2) == 0) begin
                check($sformatf("zero_owner%0d", k), 32'(owner_z), 32'((k / 2) % 2));
                check($sformatf("zero_data%0d", k), data_z,
                      ((k / 2) % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0001);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Round-robin arbiter that shares the 8-digit seven-segment display driver between several requesters, such as the CPU store path and debug sources (PC, register snoop). It accepts one 32-bit value at a time from the winning requester and issues a single-cycle chip-select write to the display driver. It then holds the display for a programmable minimum time before granting again, so every value stays visible. It sits between the requesters and the display driver's `cs`/`i_data` inputs.

## Interface
- `NREQ`, default 3: number of requesters; valid range 2..4.
- `HOLD_CYCLES`, default 50000000: minimum cycles a written value stays on the display before the next grant; 0 is legal.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NREQ: request per requester; level, held until ack.
- `req_data` in 32*NREQ: flattened data; requester i uses bits [32*i+31:32*i]; stable while req[i] high.
- `ack` out NREQ: one-hot, one-cycle pulse; the requester's value has been captured.
- `o_cs` out 1: one-cycle write strobe to the display driver.
- `o_data` out 32: value for the display driver; valid whenever o_cs is high and held afterwards.
- `o_owner` out 2: index of the requester whose value is currently displayed.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - WRITE: strobe the display driver; lasts exactly 1 cycle.
  - HOLD: count down the hold time.
- IDLE, req != 0: select winner g by round-robin search from pointer ptr upward, wrapping modulo NREQ. On the same edge:
  - o_data <= req_data slice g
  - ack <= one-hot g
  - o_owner <= g
  - ptr <= (g+1) mod NREQ
  - state <= WRITE
- IDLE, req == 0: stay in IDLE; ack = 0.
- WRITE: o_cs = 1 and ack remains high for this single cycle. Next state is HOLD with cnt <= HOLD_CYCLES-1, or IDLE directly if HOLD_CYCLES == 0.
- HOLD: if cnt == 0, go to IDLE; otherwise cnt <= cnt-1. Requests are ignored and not latched.
- The cnt register is wide enough for HOLD_CYCLES-1; there is no wrap.
- req is sampled only in IDLE. A req still high when IDLE is next entered counts as a new request.
- o_data and o_owner keep their last values outside WRITE.
- Reset values: state IDLE, ptr 0, cnt 0, o_data 0, o_owner 0, ack 0, o_cs 0, busy 0.
- Reset mid-operation (WRITE or HOLD): abort immediately and return to reset values. The display driver keeps whatever it last latched. A pending ack or o_cs is dropped.
- Requester index ≥ NREQ is never granted.

## Timing
- Grant edge E0: ack[g], o_cs and the new o_data are all high/valid in the cycle after E0.
- busy rises on E0 and falls at E0 + HOLD_CYCLES + 1, which is the IDLE entry.
- Earliest next grant edge is E0 + HOLD_CYCLES + 2. With HOLD_CYCLES = 0, grants repeat every 2 cycles.
- Latency from req rising (in IDLE) to ack is 1 edge.
- o_cs is never high in two consecutive cycles.
- Outputs are glitch-free: ack, o_cs, busy and o_data are registered, or decoded directly from the state register.

## Test plan
The bench builds with NREQ=3 and HOLD_CYCLES=4 unless stated.
- **Idle after reset:** reset pulse, then req=0 for 50 cycles -> o_cs and ack stay 0; o_data=0; busy=0.
- **Single request:** req[1]=1 with data 0x12345678 -> ack=3'b010 and o_cs=1 together for exactly one cycle; o_data=0x12345678; o_owner=1; busy high for 5 cycles; req dropped after ack gives no further o_cs.
- **Round-robin order:** req=3'b111 held continuously from reset -> grants 0,1,2,0,1 in that order; consecutive grant edges exactly 6 cycles apart; each o_data matches the granted slice.
- **Requests during HOLD:** req[2] rises during HOLD of a req[0] grant -> no ack until IDLE; then ack[2] on the first IDLE edge; ptr is respected, e.g. req=3'b101 after granting 0 grants 2.
- **Reset mid-HOLD:** reset asserted during the HOLD cycle with cnt=2 -> busy=0, o_cs=0, o_data=0, o_owner=0 immediately; first grant after release goes to requester 0 when req=3'b111.
- **Zero hold:** HOLD_CYCLES=0 build with req=3'b011 held -> o_cs pulses every 2nd cycle; owners alternate 0,1.
